// File: rtl/addsub_serial.sv
// Chunk-serial two's-complement adder/subtractor: one CHUNK-bit slice per cycle, valid/ready on both sides.
// Optional condition flags are built only when ADDSUB_SERIAL_FLAGS_EN is defined; otherwise they read 0.
module addsub_serial #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             carry,
  output logic             zero,
  output logic             sign
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [KW-1:0]     r_k;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_result;
  logic              r_carry;
  logic [CHUNK-1:0]  w_aChunk;
  logic [CHUNK-1:0]  w_bChunk;
  logic [CHUNK:0]    w_sum;
  logic              w_accept;
  logic              w_lastChunk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nextState = BUSY;
      end
      BUSY: begin
        if (w_lastChunk) w_nextState = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_accept    = in_ready && in_valid;
  assign w_lastChunk = (r_k == KW'(NCHUNK - 1));

  // Constant-index mux keeps the chunk select free of variable part-selects.
  always_comb begin
    w_aChunk = '0;
    w_bChunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_k == KW'(i)) begin
        w_aChunk = r_a[i*CHUNK +: CHUNK];
        w_bChunk = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  assign w_sum = {1'b0, w_aChunk} + {1'b0, w_bChunk} + {{CHUNK{1'b0}}, r_carry};

  // Subtraction is a + ~b + 1: b is inverted and the carry-in seeded at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b ^ {WIDTH{op}};
      r_carry <= op;
      r_k     <= '0;
    end else if (r_state == BUSY) begin
      for (int i = 0; i < NCHUNK; i++) begin
        if (r_k == KW'(i)) r_result[i*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
      end
      r_carry <= w_sum[CHUNK];
      if (!w_lastChunk) r_k <= r_k + KW'(1);
    end
  end

  assign result = r_result;

`ifdef ADDSUB_SERIAL_FLAGS_EN
  logic [WIDTH-1:0] w_finalResult;
  logic             r_overflow;
  logic             r_carryFlag;
  logic             r_zero;
  logic             r_sign;

  // The top chunk is still in flight on the last BUSY cycle, so flags see it merged in.
  always_comb begin
    w_finalResult = r_result;
    w_finalResult[WIDTH-1 -: CHUNK] = w_sum[CHUNK-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_carryFlag <= 1'b0;
      r_zero      <= 1'b0;
      r_sign      <= 1'b0;
    end else if (r_state == BUSY && w_lastChunk) begin
      r_overflow  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                     (w_finalResult[WIDTH-1] != r_a[WIDTH-1]);
      r_carryFlag <= w_sum[CHUNK];
      r_zero      <= (w_finalResult == '0);
      r_sign      <= w_finalResult[WIDTH-1];
    end
  end

  assign overflow = r_overflow;
  assign carry    = r_carryFlag;
  assign zero     = r_zero;
  assign sign     = r_sign;
`else
  assign overflow = 1'b0;
  assign carry    = 1'b0;
  assign zero     = 1'b0;
  assign sign     = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: directed corner cases, backpressure, mid-operation reset,
// then randomized operations checked against an arithmetic reference model.
module tb_addsub_serial;

  localparam int WIDTH  = 64;
  localparam int CHUNK  = 16;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             carry;
  logic             zero;
  logic             sign;

  int testCount = 0;
  int failCount = 0;
  bit flagsOn;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .carry     (carry),
    .zero      (zero),
    .sign      (sign)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: plain wide arithmetic; overflow means the true signed value does not fit in 64 bits.
  task automatic modelOp(input logic iOp, input logic [63:0] iA, input logic [63:0] iB,
                         output logic [63:0] eRes, output logic eOvf, output logic eCar,
                         output logic eZero, output logic eSign);
    logic signed [65:0] trueVal;
    logic [64:0]        wideSum;
    eRes    = iOp ? (iA - iB) : (iA + iB);
    trueVal = iOp ? ($signed({{2{iA[63]}}, iA}) - $signed({{2{iB[63]}}, iB}))
                  : ($signed({{2{iA[63]}}, iA}) + $signed({{2{iB[63]}}, iB}));
    wideSum = {1'b0, iA} + {1'b0, iB};
    eCar    = iOp ? (iA >= iB) : wideSum[64];
    eOvf    = (trueVal != $signed({{2{eRes[63]}}, eRes}));
    eZero   = (eRes == 64'd0);
    eSign   = eRes[63];
    if (!flagsOn) begin
      eOvf  = 1'b0;
      eCar  = 1'b0;
      eZero = 1'b0;
      eSign = 1'b0;
    end
  endtask

  task automatic checkFlags(input string tag, input logic eOvf, input logic eCar,
                            input logic eZero, input logic eSign);
    checkOutput({tag, "_overflow"}, 64'(overflow), 64'(eOvf));
    checkOutput({tag, "_carry"},    64'(carry),    64'(eCar));
    checkOutput({tag, "_zero"},     64'(zero),     64'(eZero));
    checkOutput({tag, "_sign"},     64'(sign),     64'(eSign));
  endtask

  // Entered and left at 1 time unit after a rising edge with the DUT idle.
  task automatic applyStimulus(input string tag, input logic iOp, input logic [63:0] iA,
                               input logic [63:0] iB, input int holdCycles);
    logic [63:0] eRes;
    logic        eOvf, eCar, eZero, eSign;
    int          lat;
    modelOp(iOp, iA, iB, eRes, eOvf, eCar, eZero, eSign);
    checkOutput({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op       = iOp;
    a        = iA;
    b        = iB;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op       = 1'($urandom);
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 20) begin
      checkOutput({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(NCHUNK));
    checkOutput({tag, "_result"}, result, eRes);
    checkFlags(tag, eOvf, eCar, eZero, eSign);
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk); #1;
      checkOutput({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      checkOutput({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      checkOutput({tag, "_hold_result"}, result, eRes);
      checkFlags({tag, "_hold"}, eOvf, eCar, eZero, eSign);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
    checkOutput({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_post_retain"}, result, eRes);
  endtask

  initial begin
    logic        rOp;
    logic [63:0] rA, rB;
`ifdef ADDSUB_SERIAL_FLAGS_EN
    flagsOn = 1'b1;
`else
    flagsOn = 1'b0;
`endif
    rst       = 1'b1;
    in_valid  = 1'b1;
    op        = 1'b0;
    a         = 64'd5;
    b         = 64'd3;
    out_ready = 1'b0;
    #2;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_result", result, 64'd0);
    checkFlags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("no_accept_in_reset", 64'(in_ready), 64'd1);

    applyStimulus("sub_5_3", 1'b1, 64'd5, 64'd3, 0);
    applyStimulus("sub_min_1", 1'b1, 64'h8000_0000_0000_0000, 64'd1, 0);
    applyStimulus("add_m1_1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    applyStimulus("backpressure", 1'b0, 64'h0123_4567_89AB_CDEF, 64'h7654_3210_FEDC_BA98, 10);
    applyStimulus("after_bp", 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 0);

    // Abort in the second BUSY cycle; nothing partial may surface.
    in_valid = 1'b1;
    op       = 1'b0;
    a        = 64'h0000_0000_0000_FFFF;
    b        = 64'h0000_0000_0000_1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_result", result, 64'd0);
    checkFlags("abort", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_stays_idle", 64'(out_valid), 64'd0);
    applyStimulus("sub_0_0", 1'b1, 64'd0, 64'd0, 0);
    applyStimulus("sub_0_1", 1'b1, 64'd0, 64'd1, 1);
    applyStimulus("sub_0_min", 1'b1, 64'd0, 64'h8000_0000_0000_0000, 0);
    applyStimulus("add_max_1", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);

    for (int i = 0; i < 24; i++) begin
      rOp = 1'($urandom);
      rA  = {$urandom, $urandom};
      rB  = (i % 5 == 0) ? rA : {$urandom, $urandom};
      applyStimulus("random", rOp, rA, rB, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
